// File: rtl/uspi_seq_arb.sv
// uspi_seq_arb: round-robin sequencer sharing one simple SPI core between two requesters
//   mclk, puc_rst           : clock, asynchronous active-high reset
//   reqN, cfgN, wdataN      : requester N level request, CTRL[9:1] image, transmit word
//   doneN, rdataN, csN_n    : requester N completion pulse, received word, chip select (low)
//   busy                    : sequencer is running a transaction
//   m_addr/m_din/m_en/m_we  : peripheral master port into the SPI core
//   m_dout                  : SPI core read data, valid in the m_en cycle
module uspi_seq_arb #(
  parameter logic [14:0] SPI_BASE = 15'h0098,
  parameter int          CS_SETUP = 2,
  parameter int          CS_HOLD  = 2
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        req0,
  input  logic [8:0]  cfg0,
  input  logic [15:0] wdata0,
  output logic        done0,
  output logic [15:0] rdata0,
  output logic        cs0_n,
  input  logic        req1,
  input  logic [8:0]  cfg1,
  input  logic [15:0] wdata1,
  output logic        done1,
  output logic [15:0] rdata1,
  output logic        cs1_n,
  output logic        busy,
  output logic [13:0] m_addr,
  output logic [15:0] m_din,
  output logic        m_en,
  output logic [1:0]  m_we,
  input  logic [15:0] m_dout
);
  localparam logic [13:0] A_CTRL  = SPI_BASE[14:1];
  localparam logic [13:0] A_DATA  = SPI_BASE[14:1] + 14'd1;
  localparam logic [3:0]  N_SETUP = 4'(CS_SETUP - 1);
  localparam logic [3:0]  N_HOLD  = 4'(CS_HOLD - 1);
  typedef enum logic [2:0] {IDLE, SETUP, WDATA, WCTRL, POLL, RDATA, HOLD, DONE} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic        sel, rr, gidx;
  logic [15:0] ctrl, wdata;
  logic [8:0]  cfg_g;
  // both requesting: the one the pointer does not name wins
  always_comb begin
    gidx  = (req0 && req1) ? ~rr : req1;
    cfg_g = gidx ? cfg1 : cfg0;
  end
  assign busy = state != IDLE;
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      sel    <= 1'b0;
      rr     <= 1'b0;
      ctrl   <= 16'h0;
      wdata  <= 16'h0;
      m_addr <= 14'h0;
      m_din  <= 16'h0;
      m_en   <= 1'b0;
      m_we   <= 2'b00;
      cs0_n  <= 1'b1;
      cs1_n  <= 1'b1;
      done0  <= 1'b0;
      done1  <= 1'b0;
      rdata0 <= 16'h0;
      rdata1 <= 16'h0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: if (req0 || req1) begin
          state <= SETUP;
          sel   <= gidx;
          rr    <= gidx;
          // CTRL image with en forced on and iflg (bit 3) forced off
          ctrl  <= {6'b0, cfg_g, 1'b1} & 16'hFFF7;
          wdata <= gidx ? wdata1 : wdata0;
          cnt   <= N_SETUP;
          cs0_n <= gidx;
          cs1_n <= ~gidx;
        end
        SETUP: if (cnt == 4'd0) begin
          state  <= WDATA;
          m_en   <= 1'b1;
          m_we   <= 2'b11;
          m_addr <= A_DATA;
          m_din  <= wdata;
        end else cnt <= cnt - 4'd1;
        WDATA: begin
          state  <= WCTRL;
          m_addr <= A_CTRL;
          m_din  <= ctrl;
        end
        WCTRL: begin
          state <= POLL;
          m_we  <= 2'b00;
          m_din <= 16'h0;
        end
        POLL: if (!m_dout[0]) begin
          state  <= RDATA;
          m_addr <= A_DATA;
        end
        RDATA: begin
          state <= HOLD;
          m_en  <= 1'b0;
          cnt   <= N_HOLD;
          if (sel) rdata1 <= m_dout;
          else rdata0 <= m_dout;
        end
        HOLD: if (cnt == 4'd0) begin
          state <= DONE;
          cs0_n <= 1'b1;
          cs1_n <= 1'b1;
          done0 <= ~sel;
          done1 <= sel;
        end else cnt <= cnt - 4'd1;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uspi_seq_arb.sv
// tb_uspi_seq_arb: randomized bench with an SPI core model and a transaction-level reference
module tb_uspi_seq_arb;
  localparam int S = 2, H = 2;
  localparam logic [13:0] AC = 14'h004C, AD = 14'h004D;
  logic mclk = 1'b0, puc_rst;
  logic req0, req1, done0, done1, cs0_n, cs1_n, busy, m_en;
  logic [8:0] cfg0, cfg1;
  logic [15:0] wdata0, wdata1, rdata0, rdata1, m_din, m_dout;
  logic [13:0] m_addr;
  logic [1:0] m_we;
  uspi_seq_arb dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .req0(req0), .cfg0(cfg0), .wdata0(wdata0), .done0(done0), .rdata0(rdata0), .cs0_n(cs0_n),
    .req1(req1), .cfg1(cfg1), .wdata1(wdata1), .done1(done1), .rdata1(rdata1), .cs1_n(cs1_n),
    .busy(busy), .m_addr(m_addr), .m_din(m_din), .m_en(m_en), .m_we(m_we), .m_dout(m_dout)
  );
  always #5 mclk = ~mclk;
  function automatic int blen(input logic [15:0] c);
    return (c[9] ? 16 : 8) + 2 * int'(c[8:6]);
  endfunction
  logic en_c;
  logic [5:0] cnt_c;
  logic [15:0] rx = 16'h0;
  assign m_dout = (m_addr == AD) ? rx : {15'b0, en_c};
  always @(posedge mclk or posedge puc_rst)
    if (puc_rst) begin en_c <= 1'b0; cnt_c <= 6'd0; end
    else if (m_en && m_we == 2'b11 && m_addr == AC) begin en_c <= m_din[0]; cnt_c <= 6'(blen(m_din)); end
    else if (en_c) begin if (cnt_c == 6'd1) en_c <= 1'b0; cnt_c <= cnt_c - 6'd1; end
  int n_wr = 0, polls = 0, reads = 0, cs_cyc = 0, both_low = 0, odd_bus = 0;
  logic [13:0] wr_a [2];
  logic [15:0] wr_d [2];
  always @(negedge mclk) if (!puc_rst) begin
    if (m_en && m_we == 2'b11) begin
      if (n_wr < 2) begin wr_a[n_wr] = m_addr; wr_d[n_wr] = m_din; end
      n_wr++;
    end
    if (m_en && m_we == 2'b00 && m_addr == AC) polls++;
    if (m_en && m_we == 2'b00 && m_addr == AD) reads++;
    if (m_en && (!(m_we inside {2'b00, 2'b11}) || !(m_addr inside {AC, AD}))) odd_bus++;
    if (!cs0_n || !cs1_n) cs_cyc++;
    if (!cs0_n && !cs1_n) both_low++;
  end
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin bad++; $display("FAIL %s got=%0h exp=%0h", tag, got, exp); end
  endtask
  task automatic tick;
    @(negedge mclk); #1;
  endtask
  task automatic clr_mon;
    n_wr = 0; polls = 0; reads = 0; cs_cyc = 0;
  endtask
  logic [15:0] resp [2];
  task automatic set_in(input logic i, input logic [8:0] c, input logic [15:0] w, input logic [15:0] r);
    if (i) begin cfg1 = c; wdata1 = w; end else begin cfg0 = c; wdata0 = w; end
    resp[i] = r;
  endtask
  initial begin
    logic g, rereq, rr_m;
    logic [1:0] pend;
    int n, b, p, k;
    logic [15:0] ce, we, re;
    req0 = 0; req1 = 0; cfg0 = 0; cfg1 = 0; wdata0 = 0; wdata1 = 0; resp[0] = 0; resp[1] = 0;
    puc_rst = 1;
    repeat (3) tick;
    chk("rst_cs", 32'({cs1_n, cs0_n}), 32'h3);
    chk("rst_bus", 32'({m_en, m_we}), 32'h0);
    chk("rst_addr", 32'(m_addr), 32'h0);
    chk("rst_din", 32'(m_din), 32'h0);
    chk("rst_flags", 32'({busy, done1, done0}), 32'h0);
    chk("rst_rdata", {rdata1, rdata0}, 32'h0);
    puc_rst = 0;
    tick;
    pend = 0; rr_m = 0; p = 0; k = 0;
    for (int t = 0; t < 40; t++) begin
      if (pend == 2'b00) begin
        p++; k = 0;
        if (p == 1) begin pend = 2'b01; set_in(0, 9'h020, 16'h00A5, 16'h003C); end
        else if (p == 3) begin pend = 2'b10; set_in(1, 9'h180, 16'hBEEF, 16'($urandom)); end
        else begin
          pend = (p == 2) ? 2'b11 : 2'($urandom_range(1, 3));
          set_in(0, 9'($urandom), 16'($urandom), 16'($urandom));
          set_in(1, 9'($urandom), 16'($urandom), 16'($urandom));
        end
        req0 = pend[0]; req1 = pend[1];
      end
      g = (pend == 2'b11) ? ~rr_m : pend[1];
      rr_m = g;
      n = 0;
      while (cs0_n && cs1_n && n < 50) begin tick; n++; end
      chk("grant_seen", 32'(n < 50), 32'h1);
      chk("grant_cs", 32'({cs1_n, cs0_n}), g ? 32'h1 : 32'h2);
      chk("grant_busy", 32'(busy), 32'h1);
      ce = ((16'(g ? cfg1 : cfg0) << 1) & 16'hFFF7) | 16'h0001;
      we = g ? wdata1 : wdata0;
      re = ce[9] ? resp[g] : {8'h00, resp[g][7:0]};
      rx = re;
      if (g) begin cfg1 = 9'($urandom); wdata1 = 16'($urandom); end
      else begin cfg0 = 9'($urandom); wdata0 = 16'($urandom); end
      if (p > 3 && $urandom_range(0, 3) == 0) begin if (g) req1 = 0; else req0 = 0; end
      if (p == 5 && k == 0) begin
        n = 0;
        while (polls == 0 && n < 50) begin tick; n++; end
        chk("poll_seen", 32'(n < 50), 32'h1);
        puc_rst = 1;
        #1;
        chk("prst_cs", 32'({cs1_n, cs0_n}), 32'h3);
        chk("prst_bus", 32'({m_en, m_we}), 32'h0);
        chk("prst_flags", 32'({busy, done1, done0}), 32'h0);
        tick; tick;
        puc_rst = 0;
        req0 = 0; req1 = 0; pend = 0; rr_m = 0;
        clr_mon;
        repeat (3) begin tick; chk("prst_idle", 32'({busy, done1, done0}), 32'h0); end
        continue;
      end
      n = 0;
      while (!done0 && !done1 && n < 300) begin tick; n++; end
      chk("done_seen", 32'(n < 300), 32'h1);
      b = blen(ce) + 1;
      chk("done_idx", 32'({done1, done0}), g ? 32'h2 : 32'h1);
      chk("latency", 32'(n), 32'(S + 3 + b + H));
      chk("rdata", 32'(g ? rdata1 : rdata0), 32'(re));
      chk("n_wr", 32'(n_wr), 32'h2);
      chk("wr_data_addr", 32'(wr_a[0]), 32'(AD));
      chk("wr_data", 32'(wr_d[0]), 32'(we));
      chk("wr_ctrl_addr", 32'(wr_a[1]), 32'(AC));
      chk("wr_ctrl", 32'(wr_d[1]), 32'(ce));
      chk("polls", 32'(polls), 32'(b));
      chk("reads", 32'(reads), 32'h1);
      chk("cs_cycles", 32'(cs_cyc), 32'(S + 3 + b + H));
      chk("cs_overlap", 32'(both_low), 32'h0);
      chk("bus_shape", 32'(odd_bus), 32'h0);
      chk("cs_released", 32'({cs1_n, cs0_n}), 32'h3);
      pend[g] = 1'b0;
      rereq = (p == 2 && k < 3) || (p > 3 && $urandom_range(0, 2) == 0);
      if (rereq) begin pend[g] = 1'b1; set_in(g, 9'($urandom), 16'($urandom), 16'($urandom)); end
      if (g) req1 = pend[1]; else req0 = pend[0];
      k++;
      clr_mon;
      tick;
      chk("done_pulse", 32'({busy, done1, done0}), 32'h0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
